// File: rtl/truth_table_extractor_if.sv
// Bundle between the truth-table extractor and the harness around it:
// sweep request/expectation, DUT drive/observe, and the captured result.
interface truth_table_extractor_if #(
    parameter int N_IN = 3
);
    localparam int TT_W = 2 ** N_IN;

    logic            start;
    logic [TT_W-1:0] expect_tt;
    logic [N_IN-1:0] in_vec;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] table_out;
    logic            tt_valid;
    logic            match;

    modport master (
        output start, expect_tt, dut_out,
        input  in_vec, busy, done, table_out, tt_valid, match
    );

    modport slave (
        input  start, expect_tt, dut_out,
        output in_vec, busy, done, table_out, tt_valid, match
    );
endinterface

// File: rtl/truth_table_extractor.sv
// Walks a combinational gate through every input row, samples its output and
// packs the truth table MSB-first (row 0 lands in the top bit).
//
// state  | meaning
// IDLE   | waiting for start; result registers hold the last sweep
// SETTLE | in_vec held while the gate output settles
// SAMPLE | dut_out captured into the table bit for the current row
// DONE   | table final; publish done/tt_valid/match for one cycle
module truth_table_extractor #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                   clk,
    input logic                   rst,
    truth_table_extractor_if.slave bus
);
    localparam int TT_W  = 2 ** N_IN;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [N_IN:0] ROW_LAST = (N_IN + 1)'(TT_W - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam state_t ROW_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t          state;
    logic [N_IN:0]   row;
    logic [CNT_W-1:0] settle_cnt;
    logic [N_IN-1:0] in_vec_q;
    logic            busy_q;
    logic            done_q;
    logic [TT_W-1:0] table_q;
    logic            tt_valid_q;
    logic            match_q;
    logic [N_IN-1:0] bit_idx;

    // table index TT_W-1-row is simply the bitwise complement of the row
    assign bit_idx = ~row[N_IN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            settle_cnt <= '0;
            in_vec_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
            tt_valid_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        row        <= '0;
                        in_vec_q   <= '0;
                        settle_cnt <= '0;
                        busy_q     <= 1'b1;
                        tt_valid_q <= 1'b0;
                        match_q    <= 1'b0;
                        table_q    <= '0;
                        state      <= ROW_ENTRY;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    table_q[bit_idx] <= bus.dut_out;
                    if (row == ROW_LAST) begin
                        state <= DONE;
                    end else begin
                        row        <= row + 1'b1;
                        in_vec_q   <= in_vec_q + 1'b1;
                        settle_cnt <= '0;
                        state      <= ROW_ENTRY;
                    end
                end
                DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    tt_valid_q <= 1'b1;
                    match_q    <= (table_q == bus.expect_tt);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_vec    = in_vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.tt_valid  = tt_valid_q;
    assign bus.match     = match_q;
endmodule
